// File: rtl/maxpool1d_pack.sv
// maxpool1d_pack: 1-D max pooling along x per channel on the conv1d output
// stream, int8 saturation, little-endian packing of four bytes per word and an
// output FIFO drained by the CPU.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_RUN   | accepting samples, pooling and packing
// ST_FLUSH | end of sequence: push any partial word, drop partial windows
module maxpool1d_pack #(
   parameter int BYTE_SIZE    = 8,
   parameter int INT32_SIZE   = 32,
   parameter int MAX_CHANNELS = 128,
   parameter int FIFO_DEPTH   = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cfg_we,
   input  logic [7:0]                  cfg_channels,
   input  logic [2:0]                  cfg_pool,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [INT32_SIZE-1:0]       in_data,
   input  logic                        flush,
   output logic                        flush_done,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [INT32_SIZE-1:0]       out_data,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        busy
);

   localparam int LANES  = INT32_SIZE / BYTE_SIZE;
   localparam int LANE_W = $clog2(LANES);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int IDX_W  = $clog2(MAX_CHANNELS);

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   localparam logic signed [INT32_SIZE-1:0] SAT_HI = INT32_SIZE'(2**(BYTE_SIZE-1) - 1);
   localparam logic signed [INT32_SIZE-1:0] SAT_LO = ~SAT_HI;

   logic [0:0]                    state;
   logic [7:0]                    channels;
   logic [7:0]                    chan_idx;
   logic [2:0]                    pool;
   logic [2:0]                    pool_idx;
   logic [2:0]                    pool_cfg;
   logic [LANE_W-1:0]             byte_cnt;
   logic [INT32_SIZE-1:0]         part_word;
   logic [INT32_SIZE-1:0]         next_word;
   logic signed [BYTE_SIZE-1:0]   max_buf [MAX_CHANNELS];
   logic signed [BYTE_SIZE-1:0]   sample_sat;
   logic signed [BYTE_SIZE-1:0]   buf_val;
   logic signed [BYTE_SIZE-1:0]   pooled;
   logic [INT32_SIZE-1:0]         fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]              wr_ptr;
   logic [PTR_W-1:0]              rd_ptr;
   logic [CNT_W-1:0]              count;
   logic                          fifo_full;
   logic                          xfer;
   logic                          emit;
   logic                          word_done;
   logic                          flush_push;
   logic                          push;
   logic                          pop;
   logic [INT32_SIZE-1:0]         push_data;
   logic                          last_chan;
   logic                          last_row;

   assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
   assign last_chan = (chan_idx == channels - 8'd1);
   assign last_row  = (pool_idx == pool - 3'd1);

   // A config write in the same cycle wins, so the handshake is withheld then.
   assign in_ready = !rst && !cfg_we && (state == ST_RUN) && (channels != 8'd0) && !fifo_full;
   assign xfer     = in_valid && in_ready;
   assign emit     = xfer && last_row;
   assign word_done = emit && (byte_cnt == LANE_W'(LANES - 1));

   assign flush_done = !rst && !cfg_we && (state == ST_FLUSH) && ((byte_cnt == '0) || !fifo_full);
   assign flush_push = flush_done && (byte_cnt != '0);

   assign push      = word_done || flush_push;
   assign push_data = word_done ? next_word : part_word;

   assign out_valid  = !rst && (count != '0);
   assign pop        = out_valid && out_ready;
   assign out_data   = out_valid ? fifo_mem[rd_ptr] : '0;
   assign fifo_count = rst ? '0 : count;
   assign busy       = !rst && ((state == ST_FLUSH) || (byte_cnt != '0) ||
                                ((pool != 3'd1) && ((pool_idx != 3'd0) || (chan_idx != 8'd0))));

   // Pool window from the config bus: 0 means 1, anything above 4 means 4.
   always_comb begin
      if (cfg_pool == 3'd0)
         pool_cfg = 3'd1;
      else if (cfg_pool > 3'd4)
         pool_cfg = 3'd4;
      else
         pool_cfg = cfg_pool;
   end

   // Saturate the sample to int8 and fold it into this channel's running max.
   always_comb begin
      if ($signed(in_data) > SAT_HI)
         sample_sat = BYTE_SIZE'(SAT_HI);
      else if ($signed(in_data) < SAT_LO)
         sample_sat = BYTE_SIZE'(SAT_LO);
      else
         sample_sat = in_data[BYTE_SIZE-1:0];
      buf_val = max_buf[chan_idx[IDX_W-1:0]];
      if ((pool_idx == 3'd0) || (sample_sat > buf_val))
         pooled = sample_sat;
      else
         pooled = buf_val;
   end

   // Word as it looks with the pooled byte dropped into the current lane.
   always_comb begin
      next_word = part_word;
      next_word[int'(byte_cnt) * BYTE_SIZE +: BYTE_SIZE] = pooled;
   end

   // Running-max buffer; only ever written by an accepted sample.
   always_ff @(posedge clk) begin
      if (xfer)
         max_buf[chan_idx[IDX_W-1:0]] <= pooled;
   end

   // Config, channel/pool position, packer and RUN/FLUSH sequencing.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         channels  <= 8'd1;
         pool      <= 3'd1;
         chan_idx  <= '0;
         pool_idx  <= '0;
         byte_cnt  <= '0;
         part_word <= '0;
      end else if (cfg_we) begin
         state     <= ST_RUN;
         channels  <= cfg_channels;
         pool      <= pool_cfg;
         chan_idx  <= '0;
         pool_idx  <= '0;
         byte_cnt  <= '0;
         part_word <= '0;
      end else begin
         if (xfer) begin
            if (last_chan) begin
               chan_idx <= '0;
               pool_idx <= last_row ? 3'd0 : pool_idx + 3'd1;
            end else begin
               chan_idx <= chan_idx + 8'd1;
            end
            if (emit) begin
               if (word_done) begin
                  part_word <= '0;
                  byte_cnt  <= '0;
               end else begin
                  part_word <= next_word;
                  byte_cnt  <= byte_cnt + LANE_W'(1);
               end
            end
         end
         if (state == ST_RUN) begin
            if (flush)
               state <= ST_FLUSH;
         end else if (flush_done) begin
            part_word <= '0;
            byte_cnt  <= '0;
            chan_idx  <= '0;
            pool_idx  <= '0;
            state     <= ST_RUN;
         end
      end
   end

   // FIFO storage; unused upper lanes of a partial word are already zero.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= push_data;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_maxpool1d_pack.sv
// Bench for maxpool1d_pack: reference model of pooling/packing feeds a
// scoreboard queue; a monitor pops it whenever the DUT hands out a word.
module tb_maxpool1d_pack;

   localparam int FIFO_DEPTH = 64;

   logic        clk;
   logic        rst;
   logic        cfg_we;
   logic [7:0]  cfg_channels;
   logic [2:0]  cfg_pool;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        flush;
   logic        flush_done;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [6:0]  fifo_count;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];
   int          win[$];
   logic [7:0]  bytes_q[$];
   int          m_ch   = 1;
   int          m_pool = 1;
   bit          rand_ready  = 0;
   bit          ready_force = 0;

   maxpool1d_pack #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_we       (cfg_we),
      .cfg_channels (cfg_channels),
      .cfg_pool     (cfg_pool),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .flush        (flush),
      .flush_done   (flush_done),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .fifo_count   (fifo_count),
      .busy         (busy)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int sat8(input int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   function automatic void emit_byte(input int b);
      logic [31:0] w;
      logic [7:0]  b8;
      b8 = 8'(b);
      bytes_q.push_back(b8);
      if (bytes_q.size() == 4) begin
         w = {bytes_q[3], bytes_q[2], bytes_q[1], bytes_q[0]};
         exp_q.push_back(w);
         bytes_q.delete();
      end
   endfunction

   // The window is kept as raw rows; a channel's pooled value is the max over
   // its column once its last row arrives.
   function automatic void model_accept(input int v);
      int idx, r, c, mx;
      idx = win.size();
      r = idx / m_ch;
      c = idx % m_ch;
      win.push_back(sat8(v));
      if (r == m_pool - 1) begin
         mx = win[c];
         for (int rr = 1; rr <= r; rr++)
            if (win[rr * m_ch + c] > mx) mx = win[rr * m_ch + c];
         emit_byte(mx);
      end
      if (win.size() == m_ch * m_pool) win.delete();
   endfunction

   function automatic void model_flush();
      logic [31:0] w;
      if (bytes_q.size() > 0) begin
         w = '0;
         for (int i = 0; i < bytes_q.size(); i++) w[i*8 +: 8] = bytes_q[i];
         exp_q.push_back(w);
      end
      bytes_q.delete();
      win.delete();
   endfunction

   function automatic void model_cfg(input int ch, input int pl);
      m_ch   = ch;
      m_pool = (pl == 0) ? 1 : (pl > 4) ? 4 : pl;
      bytes_q.delete();
      win.delete();
   endfunction

   function automatic int rnd_val();
      if ($urandom_range(0, 3) == 0) return int'($urandom);
      return int'($urandom_range(0, 400)) - 200;
   endfunction

   // ---------------- consumer side ----------------
   initial begin
      out_ready = 0;
      forever begin
         @(posedge clk);
         #2;
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
      end
   end

   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         check("fifo_count_bound", 64'(fifo_count <= FIFO_DEPTH), 64'd1);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_word: got 0x%0h expected none", out_data);
            end else begin
               e = exp_q.pop_front();
               check("out_word", out_data, e);
            end
         end
      end
   end

   // ---------------- stimulus helpers (called at posedge+1) ----------------
   task automatic send(input int v);
      bit ok = 0;
      in_valid = 1;
      in_data  = v;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (ok) model_accept(v);
      else begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0 expected 1");
      end
      @(posedge clk);
      #1;
      in_valid = 0;
   endtask

   task automatic do_cfg(input int ch, input int pl);
      cfg_we       = 1;
      cfg_channels = 8'(ch);
      cfg_pool     = 3'(pl);
      model_cfg(ch, pl);
      @(posedge clk);
      #1;
      cfg_we = 0;
   endtask

   task automatic do_flush(input bit exp_immediate);
      int pulses = 0;
      int first  = -1;
      flush = 1;
      @(posedge clk);
      #1;
      flush = 0;
      model_flush();
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         if (flush_done) begin
            pulses++;
            if (first < 0) first = t;
         end
      end
      @(posedge clk);
      #1;
      check("flush_done_pulses", 64'(pulses), 64'd1);
      if (exp_immediate) check("flush_done_latency", 64'(first), 64'd0);
   endtask

   task automatic drain();
      bit done = 0;
      ready_force = 1;
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) begin
            done = 1;
            break;
         end
      end
      check("drain_complete", 64'(done), 64'd1);
      @(posedge clk);
      #1;
      ready_force = 0;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int v;
      rst = 1; cfg_we = 0; cfg_channels = 0; cfg_pool = 0;
      in_valid = 0; in_data = 0; flush = 0;
      to_pos();
      at_neg();
      check("rst_in_ready", 64'(in_ready), 0);
      check("rst_out_valid", 64'(out_valid), 0);
      check("rst_fifo_count", 64'(fifo_count), 0);
      check("rst_flush_done", 64'(flush_done), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_out_data", 64'(out_data), 0);
      to_pos();
      rst = 0;
      at_neg();
      check("post_rst_in_ready", 64'(in_ready), 1);
      to_pos();

      // channels=2, pool=2: one full word
      do_cfg(2, 2);
      send(5); send(-3); send(2); send(7); send(1); send(1); send(9);
      at_neg();
      check("t1_no_word_yet", 64'(out_valid), 0);
      check("t1_busy_mid", 64'(busy), 1);
      to_pos();
      send(-8);
      at_neg();
      check("t1_latency_valid", 64'(out_valid), 1);
      check("t1_count", 64'(fifo_count), 1);
      check("t1_word", 64'(out_data), 64'h0109_0705);
      check("t1_busy_end", 64'(busy), 0);
      to_pos();
      drain();

      // pool=1, channels=3: saturation and partial word on flush
      do_cfg(3, 1);
      send(300); send(-300); send(4);
      at_neg();
      check("t2_busy_partial", 64'(busy), 1);
      to_pos();
      do_flush(1);
      at_neg();
      check("t2_flush_word", 64'(out_data), 64'h0004_807F);
      check("t2_busy_after", 64'(busy), 0);
      to_pos();
      drain();

      // incomplete pool window is dropped
      do_cfg(1, 4);
      send(1); send(2); send(3);
      at_neg();
      check("t3_busy_window", 64'(busy), 1);
      to_pos();
      do_flush(1);
      at_neg();
      check("t3_no_word", 64'(fifo_count), 0);
      check("t3_busy_after", 64'(busy), 0);
      to_pos();
      send(10); send(20); send(30); send(40);
      send(5); send(6); send(7); send(8);
      send(1); send(1); send(1); send(-9);
      send(-5); send(-6); send(-7); send(-8);
      at_neg();
      check("t3_fresh_window_word", 64'(out_data), 64'hFB01_0828);
      to_pos();
      drain();

      // channels=0 blocks input
      do_cfg(0, 1);
      at_neg();
      check("ch0_in_ready", 64'(in_ready), 0);
      to_pos();

      // randomized configurations and data
      for (int r = 0; r < 6; r++) begin
         do_cfg(int'($urandom_range(1, 6)), int'($urandom_range(0, 7)));
         rand_ready = 1;
         for (int i = 0; i < int'($urandom_range(10, 60)); i++) send(rnd_val());
         do_flush(0);
         rand_ready = 0;
         drain();
      end

      // backpressure with a full FIFO
      do_cfg(1, 1);
      for (int i = 0; i < 4 * FIFO_DEPTH; i++) send(rnd_val());
      at_neg();
      check("bp_full_count", 64'(fifo_count), 64'(FIFO_DEPTH));
      check("bp_full_ready", 64'(in_ready), 0);
      to_pos();
      v = rnd_val();
      in_valid = 1; in_data = v; ready_force = 1;
      at_neg();
      check("bp_pop_cycle_ready", 64'(in_ready), 0);
      to_pos();
      ready_force = 0;
      at_neg();
      check("bp_after_pop_ready", 64'(in_ready), 1);
      check("bp_after_pop_count", 64'(fifo_count), 64'(FIFO_DEPTH - 1));
      model_accept(v);
      to_pos();
      in_valid = 0;
      do_flush(1);
      drain();

      // simultaneous push and pop at count=3
      do_cfg(1, 1);
      for (int i = 0; i < 15; i++) send(rnd_val());
      at_neg();
      check("pp_pre_count", 64'(fifo_count), 3);
      to_pos();
      v = rnd_val();
      in_valid = 1; in_data = v; ready_force = 1;
      at_neg();
      check("pp_ready", 64'(in_ready), 1);
      check("pp_valid", 64'(out_valid), 1);
      model_accept(v);
      to_pos();
      in_valid = 0; ready_force = 0;
      at_neg();
      check("pp_count_held", 64'(fifo_count), 3);
      to_pos();

      // config write mid-word discards the partial bytes only
      send(rnd_val()); send(rnd_val());
      do_cfg(1, 1);
      at_neg();
      check("cfg_mid_count", 64'(fifo_count), 3);
      check("cfg_mid_busy", 64'(busy), 0);
      to_pos();
      send(rnd_val()); send(rnd_val()); send(rnd_val()); send(rnd_val());
      at_neg();
      check("cfg_new_word_count", 64'(fifo_count), 4);
      to_pos();
      drain();

      // reset with a full FIFO and a flush request
      for (int i = 0; i < 4 * FIFO_DEPTH; i++) send(rnd_val());
      at_neg();
      check("rst_pre_full", 64'(fifo_count), 64'(FIFO_DEPTH));
      to_pos();
      flush = 1; rst = 1;
      exp_q.delete();
      model_cfg(1, 1);
      to_pos();
      flush = 0; rst = 0;
      at_neg();
      check("rst_mid_out_valid", 64'(out_valid), 0);
      check("rst_mid_count", 64'(fifo_count), 0);
      check("rst_mid_in_ready", 64'(in_ready), 1);
      for (int t = 0; t < 4; t++) begin
         check("rst_mid_no_flush_done", 64'(flush_done), 0);
         at_neg();
      end
      to_pos();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
